// File: rtl/uart_byte_fifo.sv
// Elastic byte FIFO between uart_rx and uart_tx in the serial echo path.
// Strobed writes are buffered and replayed to the transmitter, paced by tx_ready plus a holdoff window.
module uart_byte_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int HOLDOFF    = 2
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_strobe,
  input  logic                  tx_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_strobe,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  clear_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state, state_next;
  logic [7:0]             hold_cnt, hold_cnt_next;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]    count_next;
  logic                   push, pop, drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DEPTH_LOG2:0] step_count(input logic [DEPTH_LOG2:0] c,
                                                     input logic p, input logic q);
    case ({p, q})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  // Next-state: read pacing FSM and push/pop/drop decode on pre-edge state
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop           = 1'b1;
          state_next    = HOLD;
          hold_cnt_next = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_cnt <= 8'd1) begin
          state_next    = IDLE;
          hold_cnt_next = 8'd0;
        end else begin
          hold_cnt_next = hold_cnt - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    push       = in_strobe && (!full || pop);
    drop       = in_strobe && !push;
    count_next = step_count(count, push, pop);
  end

  // Register stage: control state, pointers, flags and the output byte
  always_ff @(posedge mclk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= 8'd0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      out_strobe <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_cnt_next;
      count      <= count_next;
      empty      <= (count_next == '0);
      full       <= (count_next == FULL_CNT);
      out_strobe <= pop;
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // A drop on the same edge as a clear restarts the tally at one
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= clear_overflow ? 8'd1 : sat_inc(drop_count);
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= 8'd0;
      end
    end
  end

  // Storage array carries data only and is never reset
  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
